// File: rtl/shift_arbiter_8bit.sv
// shift_arbiter_8bit
// Round-robin arbiter that shares one 8-bit, three-stage rotate-right datapath
// between NUM_REQ requesters. The rotated result goes into a single-entry output
// buffer with a requester tag. Valid/ready handshakes run on both sides.
// Optional feature macro: SHIFT_DIR_EN adds the req_dir port for left rotates.
// A left rotate is mapped onto the same right-rotate stages.
module shift_arbiter_8bit #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [3*NUM_REQ-1:0]   req_amt,
`ifdef SHIFT_DIR_EN
    input  logic [NUM_REQ-1:0]     req_dir,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [ID_W-1:0]        out_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic [7:0]      sel_data;
    logic [2:0]      sel_amt;
    logic [2:0]      eff_amt;
    logic [7:0]      rot_data;

    // Rotate right by 0..7 using three fixed stages: by 1, by 2, then by 4.
    function automatic logic [7:0] rotr8(input logic [7:0] d, input logic [2:0] amt);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        s0 = amt[0] ? {d[0],    d[7:1]}  : d;
        s1 = amt[1] ? {s0[1:0], s0[7:2]} : s0;
        s2 = amt[2] ? {s1[3:0], s1[7:4]} : s1;
        return s2;
    endfunction

    // Round-robin search. The scan starts one past the last grant.
    // Priority only moves when a request is accepted.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Operand select and rotate amount.
    // A left rotate by k becomes a right rotate by (8-k) mod 8.
    always_comb begin
        sel_data = req_data[8*win +: 8];
        sel_amt  = req_amt[3*win +: 3];
`ifdef SHIFT_DIR_EN
        eff_amt  = req_dir[win] ? 3'(3'd0 - sel_amt) : sel_amt;
`else
        eff_amt  = sel_amt;
`endif
        rot_data = rotr8(sel_data, eff_amt);
    end

    // Buffer next state and handshake. A draining buffer can take a new
    // result on the same edge, so accept depends on out_ready combinationally.
    always_comb begin
        state_d    = state_q;
        can_accept = (state_q == EMPTY) || out_ready;
        accept     = can_accept && found && !reset;
        req_ready  = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
        if (accept) begin
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // Buffer state register; reset discards any buffered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result, tag and priority pointer update only on an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= 8'h00;
            out_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            out_data   <= rot_data;
            out_id     <= win;
            last_grant <= win;
        end
    end

    assign out_valid = (state_q == FULL);

endmodule

// File: doc/shift_arbiter_8bit.md
# shift_arbiter_8bit

Round-robin arbiter and sequencer that shares one 8-bit rotate-right datapath (three mux stages: 1, 2 and 4 bits) between `NUM_REQ` requesters. The block grants at most one request per cycle and rotates the granted operand. It registers the result into a single-entry output buffer tagged with the requester index, and applies valid/ready backpressure on both sides. It sits between client blocks that need occasional rotates and the downstream consumer, so the design needs only one shifter instance.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag. Derived; do not override.
- `clk`  input  1: sole clock; rising-edge.
- `reset`  input  1: asynchronous, active-high reset.
- `req_valid`  input  NUM_REQ: bit i set means requester i presents an operation.
- `req_data`  input  8*NUM_REQ: operand of requester i in bits [8i+7:8i].
- `req_amt`  input  3*NUM_REQ: rotate amount of requester i in bits [3i+2:3i].
- `req_dir`  input  NUM_REQ: 1 = rotate left, 0 = rotate right. Present only with `SHIFT_DIR_EN`.
- `req_ready`  output  NUM_REQ: one-hot or zero; bit i high means requester i's operation is accepted this cycle.
- `out_valid`  output  1: the output buffer holds a result.
- `out_ready`  input  1: the consumer accepts the result.
- `out_data`  output  8: rotated result.
- `out_id`  output  ID_W: index of the requester that produced `out_data`.

## Operation
- Output buffer state machine with two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `can_accept` = EMPTY or (FULL and `out_ready`).
- Arbitration: round-robin over `req_valid`, starting at `last_grant`+1 mod NUM_REQ.
  - The first valid requester wins.
  - `req_ready[win]` = `can_accept`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `out_ready` and state.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Accept (`req_valid[i]` & `req_ready[i]`):
  - `out_data` <= rotr(`req_data[i]`, `req_amt[i]`).
  - `out_id` <= i.
  - `last_grant` <= i.
  - State becomes FULL.
- Rotation is mod 8:
  - Stage 0 rotates by 1 if amt[0] is set.
  - Stage 1 rotates by 2 if amt[1] is set.
  - Stage 2 rotates by 4 if amt[2] is set.
  - Amount 0 passes the operand through unchanged.
- FULL, `out_ready`=1, no winner: state becomes EMPTY. `out_data` and `out_id` hold their last values.
- FULL, `out_ready`=0: `out_data` and `out_id` stay stable and every `req_ready` is 0.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, and `out_valid` stays 1.
- `last_grant` changes only on an accept. With no accept, priority does not move.
- Requesters must hold `req_valid`, `req_data`, `req_amt` and `req_dir` stable until accepted.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=8'h00, `out_id`=0.
  - `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - State EMPTY.
  - `req_ready` is 0 while `reset` is asserted.
- Latency: a request accepted at edge N appears on `out_valid`/`out_data` immediately after edge N, that is 1 cycle.
- Throughput: one operation per cycle while `out_ready`=1.
- Fairness: with all requesters continuously valid, each is served once every NUM_REQ accepts.
- Reset asserted mid-transfer: any buffered result is discarded, outputs go to reset values at once, and arbitration restarts at requester 0.

## Configuration
- `SHIFT_DIR_EN` defined:
  - The `req_dir` port exists.
  - A left rotate by k is executed as a right rotate by (8-k) mod 8 through the same three stages.
- `SHIFT_DIR_EN` undefined:
  - The `req_dir` port is absent.
  - All operations are rotate right.
  - No subtractor or direction logic is synthesized.

## Test plan
- Reset, then requester 0 sends data 8'hB4, amt 3 (right), with `out_ready`=1 → one cycle later `out_valid`=1, `out_data`=8'h96, `out_id`=0.
- With `SHIFT_DIR_EN`: data 8'hB4, amt 3, dir=1 → `out_data`=8'hA5. Data 8'h5A, amt 0, either dir → 8'h5A.
- NUM_REQ=4, all four requesters valid continuously, `out_ready`=1 → `out_id` sequence is 0,1,2,3,0,1, and a result is produced every cycle.
- Buffer FULL with result 8'h80 (from 8'h01 amt 1), `out_ready`=0 for 5 cycles with requests pending:
  - Required: `out_data` stays 8'h80, all `req_ready` are 0, `last_grant` is unchanged.
  - When `out_ready` rises, the next winner is accepted in the same cycle.
- Only requester 2 valid after `last_grant`=3 → requester 2 is granted immediately; no idle cycles are spent scanning.
- `reset` pulsed while `out_valid`=1 and requests are pending → `out_valid`=0 and `out_data`=8'h00 immediately; the first grant after release goes to the lowest valid index.
